// File: rtl/divisor_mem_pkg.sv
// Shared constants for the divisor memory and the divisor-search controller:
// default widths, INIT/RUN state encoding and the default divisor table.
package divisor_mem_pkg;
    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 8;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DIV0_DEF = 2;
    localparam int DIV1_DEF = 3;
    localparam int DIV2_DEF = 5;
    localparam int DIV3_DEF = 7;
    localparam int FILL_DEF = 1;
    // The controller walks this many table entries.
    localparam int NUM_DIVS = 4;
endpackage

// File: rtl/divisor_mem_array.sv
// Plain 2**A_WIDTH x D_WIDTH storage: one synchronous write port and one
// registered read port. Only the read register is reset; contents are not.
module divisor_mem_array #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);
    logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/divisor_mem.sv
// Divisor table memory: self-fills with the default table after reset, then
// serves controller reads and host writes, refusing (and flagging) zero writes.
module divisor_mem
    import divisor_mem_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int DIV0    = DIV0_DEF,
    parameter int DIV1    = DIV1_DEF,
    parameter int DIV2    = DIV2_DEF,
    parameter int DIV3    = DIV3_DEF,
    parameter int FILL    = FILL_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic               Rw,
    input  logic               En,
    input  logic [D_WIDTH-1:0] WrData,
    output logic [D_WIDTH-1:0] Data,
    output logic               Ready,
    output logic               WrErr
);
    logic [0:0]         state;
    logic [A_WIDTH-1:0] ptr;
    logic               we, re;
    logic [A_WIDTH-1:0] waddr;
    logic [D_WIDTH-1:0] wdata, init_word;

    always_comb begin
        init_word = D_WIDTH'(FILL);
        if      (ptr == A_WIDTH'(0)) init_word = D_WIDTH'(DIV0);
        else if (ptr == A_WIDTH'(1)) init_word = D_WIDTH'(DIV1);
        else if (ptr == A_WIDTH'(2)) init_word = D_WIDTH'(DIV2);
        else if (ptr == A_WIDTH'(3)) init_word = D_WIDTH'(DIV3);
    end

    // The sequencer owns the write port during INIT; host accesses are dropped.
    always_comb begin
        we    = 1'b0;
        re    = 1'b0;
        waddr = Addr;
        wdata = WrData;
        if (state == ST_INIT) begin
            we    = 1'b1;
            waddr = ptr;
            wdata = init_word;
        end else if (En) begin
            if (Rw) we = |WrData;
            else    re = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
            WrErr <= 1'b0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + A_WIDTH'(1);
            if (&ptr) state <= ST_RUN;
        end else if (En && Rw && (WrData == '0)) begin
            WrErr <= 1'b1;
        end
    end

    assign Ready = (state == ST_RUN);

    divisor_mem_array #(
        .D_WIDTH(D_WIDTH),
        .A_WIDTH(A_WIDTH)
    ) u_array (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(Addr),
        .rdata(Data)
    );
endmodule

// File: tb/tb_divisor_mem.sv
// Scoreboard bench for divisor_mem: reads push expected words, a monitor
// compares Data one cycle after each read strobe.
module tb_divisor_mem;
    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] Addr;
    logic       Rw;
    logic       En;
    logic [7:0] WrData;
    logic [7:0] Data;
    logic       Ready;
    logic       WrErr;

    int total = 0;
    int bad   = 0;
    logic [7:0] expq[$];

    divisor_mem dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Addr  (Addr),
        .Rw    (Rw),
        .En    (En),
        .WrData(WrData),
        .Data  (Data),
        .Ready (Ready),
        .WrErr (WrErr)
    );

    always #5 Clk = ~Clk;

    // Monitor: a read strobe sampled at a rising edge is checked at the next falling edge.
    always @(posedge Clk) begin
        automatic logic issued = En && !Rw && Rst_n;
        @(negedge Clk);
        if (issued) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL rd_data: got %0d with no expected value queued", Data);
            end else begin
                automatic logic [7:0] e = expq.pop_front();
                if (Data !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %0d want %0d", Data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        En = 1'b0; Rw = 1'b0;
        cyc();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        En = 1'b1; Rw = 1'b0; Addr = a;
        expq.push_back(exp);
        cyc();
        En = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        En = 1'b1; Rw = 1'b1; Addr = a; WrData = d;
        cyc();
        En = 1'b0; Rw = 1'b0;
    endtask

    // Release reset and count edges until Ready; optionally poke addr 0 during INIT.
    task automatic release_and_wait(input bit poke, input string nm);
        int n;
        n = 0;
        Rst_n = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            En = 1'b0; Rw = 1'b0;
            if (poke && i == 10) begin
                En = 1'b1; Rw = 1'b0; Addr = 8'd0;
                expq.push_back(8'd0);
            end else if (poke && i == 11) begin
                En = 1'b1; Rw = 1'b1; Addr = 8'd0; WrData = 8'd9;
            end
            cyc();
            if (Ready) begin
                n = i;
                break;
            end
        end
        En = 1'b0; Rw = 1'b0;
        chk(nm, n, 256);
    endtask

    initial begin
        logic [7:0] defs [6];
        defs = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd1, 8'd1};
        Rst_n = 1'b0; En = 1'b0; Rw = 1'b0; Addr = '0; WrData = '0;
        repeat (3) cyc();
        chk("rst_data", Data, 0);
        chk("rst_ready", Ready, 0);
        chk("rst_wrerr", WrErr, 0);

        release_and_wait(1'b1, "init_cycles");
        for (int a = 0; a < 6; a++) rd(8'(a), defs[a]);
        idle();

        wr(8'd2, 8'd11);
        rd(8'd2, 8'd11);
        rd(8'd3, 8'd7);
        idle();
        chk("data_hold", Data, 7);
        wr(8'd5, 8'd4);
        chk("data_after_wr", Data, 7);
        chk("wrerr_clean", WrErr, 0);

        wr(8'd1, 8'd0);
        chk("wrerr_set", WrErr, 1);
        rd(8'd1, 8'd3);
        wr(8'd4, 8'd8);
        rd(8'd4, 8'd8);
        rd(8'd5, 8'd4);
        idle();
        chk("wrerr_sticky", WrErr, 1);

        // Asynchronous reset in RUN clears outputs without a clock edge.
        @(posedge Clk); #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_data", Data, 0);
        chk("arst_ready", Ready, 0);
        chk("arst_wrerr", WrErr, 0);
        repeat (3) cyc();

        Rst_n = 1'b1;
        repeat (100) cyc();
        chk("mid_init_ready", Ready, 0);
        Rst_n = 1'b0;
        repeat (2) cyc();
        release_and_wait(1'b0, "reinit_cycles");
        for (int a = 0; a < 6; a++) rd(8'(a), defs[a]);
        rd(8'd255, 8'd1);
        idle();
        idle();
        chk("wrerr_after_rst", WrErr, 0);
        chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
